// File: rtl/apb4_slave_regmem.sv
// apb4_slave_regmem: APB4 completer with CTRL/STATUS/WAIT_CFG/timer registers, word memory, byte strobes, wait states and slave errors
module apb4_slave_regmem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int MEM_BASE   = 'h400,
  parameter int NUM_TIMERS = 2
) (
  input  logic                    pclk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int MW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam int TW = NUM_TIMERS > 1 ? $clog2(NUM_TIMERS) : 1;
  localparam int AW = ADDR_WIDTH - 2;
  localparam logic [ADDR_WIDTH-1:0] MEM_LO = ADDR_WIDTH'(MEM_BASE);
  localparam logic [ADDR_WIDTH-1:0] MEM_HI = ADDR_WIDTH'(MEM_BASE + 4 * MEM_DEPTH);
  localparam logic [AW-1:0] W_CTRL = AW'(0);
  localparam logic [AW-1:0] W_STAT = AW'(1);
  localparam logic [AW-1:0] W_WAIT = AW'(2);
  localparam logic [AW-1:0] W_T0   = AW'(3);
  localparam logic [AW-1:0] W_TE   = AW'(3 + NUM_TIMERS);
  localparam logic [7:0]    NT     = 8'(NUM_TIMERS);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, ctrl_q, ctrl_d, wait_cfg_q, wait_cfg_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, a, moff;
  logic wr_q, wr_d, err_q, err_d, pready_q, pready_d, pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rdata, bmask;
  logic [DATA_WIDTH-1:0] timer_q [NUM_TIMERS];
  logic [DATA_WIDTH-1:0] timer_d [NUM_TIMERS];
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [AW-1:0] w;
  logic [MW-1:0] mem_idx;
  logic [TW-1:0] t_idx;
  logic wr, is_mem, is_tmr, err, commit, mem_we;
  function automatic logic [DATA_WIDTH-1:0] wmerge(input logic [DATA_WIDTH-1:0] old, m, d);
    return (old & ~m) | (d & m);
  endfunction
  always_comb begin
    for (int i = 0; i < SW; i++) bmask[8*i +: 8] = {8{pstrb[i]}};
  end
  always_comb begin
    a = state_q == S_IDLE ? paddr : addr_q;
    wr = state_q == S_IDLE ? pwrite : wr_q;
    w = a[ADDR_WIDTH-1:2];
    moff = a - MEM_LO;
    mem_idx = MW'(moff >> 2);
    t_idx = TW'(w - W_T0);
    is_mem = a >= MEM_LO && a < MEM_HI;
    is_tmr = w >= W_T0 && w < W_TE;
    err = a[1:0] != 2'b00 || !(w <= W_WAIT || is_tmr || is_mem) || (wr && w == W_STAT);
    rdata = err ? '0 :
            is_mem ? mem_q[mem_idx] :
            is_tmr ? timer_q[t_idx] :
            w == W_CTRL ? DATA_WIDTH'(ctrl_q) :
            w == W_STAT ? DATA_WIDTH'({NT, err_cnt_q}) :
            DATA_WIDTH'(wait_cfg_q);
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wr_d = wr_q;
    err_d = err_q;
    err_cnt_d = err_cnt_q;
    pready_d = 1'b0;
    pslverr_d = 1'b0;
    prdata_d = '0;
    commit = 1'b0;
    case (state_q)
      S_IDLE: if (psel && !penable) begin
        addr_d = paddr;
        wr_d = pwrite;
        err_d = err;
        cnt_d = wait_cfg_q;
        state_d = wait_cfg_q == 4'd0 ? S_ACCESS : S_WAIT;
        pready_d = wait_cfg_q == 4'd0;
        pslverr_d = wait_cfg_q == 4'd0 && err;
        prdata_d = wait_cfg_q == 4'd0 ? rdata : '0;
      end
      S_WAIT: if (!psel) state_d = S_IDLE;
      else if (cnt_q == 4'd1) begin
        state_d = S_ACCESS;
        pready_d = 1'b1;
        pslverr_d = err;
        prdata_d = rdata;
      end else cnt_d = cnt_q - 4'd1;
      default: begin
        pready_d = pready_q;
        pslverr_d = pslverr_q;
        prdata_d = prdata_q;
        if (!psel || penable) begin
          state_d = S_IDLE;
          pready_d = 1'b0;
          pslverr_d = 1'b0;
          prdata_d = '0;
        end
        if (psel && penable) begin
          commit = wr_q && !err_q;
          err_cnt_d = err_cnt_q + 8'(err_q && err_cnt_q != 8'hFF);
        end
      end
    endcase
    ctrl_d = commit && w == W_CTRL ? 4'(wmerge(DATA_WIDTH'(ctrl_q), bmask, pwdata)) : ctrl_q;
    wait_cfg_d = commit && w == W_WAIT ? 4'(wmerge(DATA_WIDTH'(wait_cfg_q), bmask, pwdata)) : wait_cfg_q;
    for (int i = 0; i < NUM_TIMERS; i++)
      timer_d[i] = commit && is_tmr && t_idx == TW'(i) ? wmerge(timer_q[i], bmask, pwdata) : timer_q[i];
    mem_we = commit && is_mem;
  end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
      ctrl_q <= '0;
      wait_cfg_q <= '0;
      pready_q <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q <= '0;
      timer_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
      ctrl_q <= ctrl_d;
      wait_cfg_q <= wait_cfg_d;
      pready_q <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q <= prdata_d;
      timer_q <= timer_d;
    end
  end
  always_ff @(posedge pclk) begin
    if (mem_we) mem_q[mem_idx] <= wmerge(mem_q[mem_idx], bmask, pwdata);
  end
  assign prdata = prdata_q;
  assign pready = pready_q;
  assign pslverr = pslverr_q;
endmodule

// File: tb/tb_apb4_slave_regmem.sv
// tb_apb4_slave_regmem: directed vector bench for apb4_slave_regmem
module tb_apb4_slave_regmem;
  logic pclk, rst_n, psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0] pstrb;
  int total, bad;
  typedef struct {
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic [31:0] rd;
    logic e;
    int waits;
  } vec_t;
  vec_t v[$];
  apb4_slave_regmem dut (
    .pclk(pclk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic e, output int waits);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 50) begin
      @(posedge pclk); #1;
      waits++;
    end
    rd = prdata;
    e = pslverr;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask
  task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] exp, input int exp_w);
    logic [31:0] rd;
    logic e;
    int wt;
    xfer(1'b0, a, 32'h0, 4'h0, rd, e, wt);
    chk({n, "_rd"}, rd, exp);
    chk({n, "_err"}, 32'(e), 32'd0);
    chk({n, "_waits"}, 32'(wt), 32'(exp_w));
  endtask
  initial begin
    logic [31:0] rd;
    logic e;
    int wt;
    total = 0; bad = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    v.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h0, 1'b0, 0});
    v.push_back('{1'b0, 32'h008, 32'h0, 4'h0, 32'h0, 1'b0, 0});
    v.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h200, 1'b0, 0});
    v.push_back('{1'b0, 32'h010, 32'h0, 4'h0, 32'h0, 1'b0, 0});
    v.push_back('{1'b1, 32'h000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0});
    v.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'h0000_000F, 1'b0, 0});
    v.push_back('{1'b1, 32'h408, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0});
    v.push_back('{1'b1, 32'h008, 32'h3, 4'hF, 32'h0, 1'b0, 0});
    v.push_back('{1'b0, 32'h008, 32'h0, 4'h0, 32'h3, 1'b0, 3});
    v.push_back('{1'b1, 32'h408, 32'hA5A5_1234, 4'h5, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h408, 32'h0, 4'h0, 32'hFFA5_FF34, 1'b0, 3});
    v.push_back('{1'b0, 32'h0FC, 32'h0, 4'h0, 32'h0, 1'b1, 3});
    v.push_back('{1'b1, 32'h004, 32'h0, 4'hF, 32'h0, 1'b1, 3});
    v.push_back('{1'b0, 32'h402, 32'h0, 4'h0, 32'h0, 1'b1, 3});
    v.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h203, 1'b0, 3});
    v.push_back('{1'b1, 32'h00C, 32'hDEAD_BEEF, 4'hC, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h00C, 32'h0, 4'h0, 32'hDEAD_0000, 1'b0, 3});
    v.push_back('{1'b1, 32'h408, 32'h0, 4'h0, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h408, 32'h0, 4'h0, 32'hFFA5_FF34, 1'b0, 3});
    v.push_back('{1'b1, 32'h000, 32'h0, 4'hE, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h000, 32'h0, 4'h0, 32'hF, 1'b0, 3});
    v.push_back('{1'b1, 32'h7FC, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h7FC, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 3});
    v.push_back('{1'b0, 32'h800, 32'h0, 4'h0, 32'h0, 1'b1, 3});
    v.push_back('{1'b0, 32'h014, 32'h0, 4'h0, 32'h0, 1'b1, 3});
    v.push_back('{1'b1, 32'h008, 32'h0, 4'hF, 32'h0, 1'b0, 3});
    v.push_back('{1'b0, 32'h008, 32'h0, 4'h0, 32'h0, 1'b0, 0});
    v.push_back('{1'b0, 32'h004, 32'h0, 4'h0, 32'h205, 1'b0, 0});
    #3;
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    @(posedge pclk); @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;
    foreach (v[i]) begin
      xfer(v[i].w, v[i].a, v[i].d, v[i].s, rd, e, wt);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(v[i].e));
      chk($sformatf("vec%0d_waits", i), 32'(wt), 32'(v[i].waits));
      if (!v[i].w) chk($sformatf("vec%0d_rd", i), rd, v[i].rd);
    end
    for (int i = 0; i < 260; i++) xfer(1'b0, 32'h0FC, 32'h0, 4'h0, rd, e, wt);
    rd_chk("sat_status", 32'h004, 32'h2FF, 0);
    rd_chk("sat_good", 32'h000, 32'hF, 0);
    rd_chk("sat_hold", 32'h004, 32'h2FF, 0);
    xfer(1'b1, 32'h008, 32'h5, 4'hF, rd, e, wt);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    chk("abort_wait1_pready", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    chk("abort_wait2_pready", 32'(pready), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_idle_pready", 32'(pready), 32'd0);
    rd_chk("abort_timer1", 32'h010, 32'h0, 5);
    rd_chk("abort_status", 32'h004, 32'h2FF, 5);
    xfer(1'b1, 32'h008, 32'h4, 4'hF, rd, e, wt);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h010; pwdata = 32'h0000_0055; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #3;
    rst_n = 1'b0;
    #1;
    chk("rstwait_pready", 32'(pready), 32'd0);
    chk("rstwait_pslverr", 32'(pslverr), 32'd0);
    chk("rstwait_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h004;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("rstacc_pre_pready", 32'(pready), 32'd1);
    chk("rstacc_pre_prdata", prdata, 32'h200);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstacc_pready", 32'(pready), 32'd0);
    chk("rstacc_prdata", prdata, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    rst_n = 1'b1;
    @(posedge pclk); #1;
    rd_chk("post_ctrl", 32'h000, 32'h0, 0);
    rd_chk("post_wait_cfg", 32'h008, 32'h0, 0);
    rd_chk("post_timer0", 32'h00C, 32'h0, 0);
    rd_chk("post_timer1", 32'h010, 32'h0, 0);
    rd_chk("post_status", 32'h004, 32'h200, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
